choose2_accum: RTL and testbench

- Consumer stage directly downstream of the Choose2 weight counter. Takes its `rd_en`/`weight_cnt` stream plus the current input feature and the weight-memory read data.
- Performs a multiply-accumulate into OUTPUT_NUM per-class accumulators over INPUT_NUM full sweeps.
- Then scans the accumulators for the argmax and reports the winning class index and score to the next stage.

---
 rtl/choose2_accum.sv | 248 ++++++++++++++++++++++++
 tb/tb_choose2_accum.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/choose2_accum.sv
// choose2_accum
//   Consumer of the Choose2 weight counter stream. Multiplies each accepted
//   feature by the weight read one cycle later and accumulates the product
//   into a per-class accumulator. After INPUT_NUM full sweeps of the class
//   index, it walks the accumulators once to find the argmax. It then reports
//   the winning class and its score.
//
// Optional feature:
//   CHOOSE2_ACC_SATURATE_EN - when defined, accumulators saturate at the
//   signed ACC_W limits and stay there until cleared. When undefined, they
//   wrap in two's complement.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   clear        synchronous abort: flush pipeline, zero accumulators
//   rd_en        weight_cnt/feature_in valid this cycle
//   weight_cnt   class index of this MAC
//   feature_in   signed feature, sampled with rd_en
//   weight_in    signed weight, valid one cycle after rd_en
//   busy         high while scanning/reporting; upstream must hold rd_en low
//   result_valid one-cycle pulse with the final result
//   class_idx    argmax class, held until the next result
//   class_score  accumulator value of the argmax class, held
module choose2_accum #(
  parameter int MEM_ADDR   = 4,
  parameter int OUTPUT_NUM = 14,
  parameter int INPUT_NUM  = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [MEM_ADDR-1:0]      weight_cnt,
  input  logic signed [DATA_W-1:0] feature_in,
  input  logic signed [DATA_W-1:0] weight_in,
  output logic                     busy,
  output logic                     result_valid,
  output logic [MEM_ADDR-1:0]      class_idx,
  output logic signed [ACC_W-1:0]  class_score
);

  localparam int SW_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam logic [MEM_ADDR:0]   NUM_CLS    = (MEM_ADDR+1)'(OUTPUT_NUM);
  localparam logic [MEM_ADDR-1:0] LAST_CLS   = MEM_ADDR'(OUTPUT_NUM - 1);
  localparam logic [SW_W-1:0]     LAST_SWEEP = SW_W'(INPUT_NUM - 1);
`ifdef CHOOSE2_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // S1: accepted request
  logic                     v1_q, v1_d;
  logic [MEM_ADDR-1:0]      cnt1_q, cnt1_d;
  logic signed [DATA_W-1:0] f1_q, f1_d;

  // S2: registered product
  logic                       v2_q, v2_d;
  logic [MEM_ADDR-1:0]        cnt2_q, cnt2_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_d;

  logic signed [ACC_W-1:0] acc_q [OUTPUT_NUM];
  logic signed [ACC_W-1:0] acc_d [OUTPUT_NUM];
`ifdef CHOOSE2_ACC_SATURATE_EN
  logic [OUTPUT_NUM-1:0]   sat_q, sat_d;
  logic [ACC_W:0]          sum_ext;
`endif

  logic [SW_W-1:0]         sweep_q, sweep_d;
  logic [MEM_ADDR-1:0]     scan_idx_q, scan_idx_d;
  logic [MEM_ADDR-1:0]     best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0] best_score_q, best_score_d;
  logic [MEM_ADDR-1:0]     class_idx_q, class_idx_d;
  logic signed [ACC_W-1:0] class_score_q, class_score_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] cur_score;
  logic signed [ACC_W-1:0] cand_score;
  logic [MEM_ADDR-1:0]     cand_idx;

  always_comb begin
    state_d       = state_q;
    v1_d          = 1'b0;
    cnt1_d        = cnt1_q;
    f1_d          = f1_q;
    v2_d          = v1_q;
    cnt2_d        = cnt1_q;
    prod_d        = f1_q * weight_in;
    acc_d         = acc_q;
    sweep_d       = sweep_q;
    scan_idx_d    = scan_idx_q;
    best_idx_d    = best_idx_q;
    best_score_d  = best_score_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    prod_ext      = ACC_W'(prod_q);
    cur_score     = '0;
    cand_score    = best_score_q;
    cand_idx      = best_idx_q;
`ifdef CHOOSE2_ACC_SATURATE_EN
    sat_d         = sat_q;
    sum_ext       = '0;
`endif

    // S1 capture; out-of-range class indices are dropped
    if ((state_q == ST_ACCUM) && rd_en && ({1'b0, weight_cnt} < NUM_CLS)) begin
      v1_d   = 1'b1;
      cnt1_d = weight_cnt;
      f1_d   = feature_in;
    end

    // S3 accumulate
    for (int unsigned i = 0; i < OUTPUT_NUM; i++) begin
      if (v2_q && (cnt2_q == MEM_ADDR'(i))) begin
`ifdef CHOOSE2_ACC_SATURATE_EN
        sum_ext = {acc_q[i][ACC_W-1], acc_q[i]} + {prod_ext[ACC_W-1], prod_ext};
        // once saturated the accumulator is frozen until cleared
        if (!sat_q[i]) begin
          if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_d[i] = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_d[i] = 1'b1;
          end else begin
            acc_d[i] = sum_ext[ACC_W-1:0];
          end
        end
`else
        acc_d[i] = acc_q[i] + prod_ext;
`endif
      end
    end

    for (int unsigned i = 0; i < OUTPUT_NUM; i++) begin
      if (scan_idx_q == MEM_ADDR'(i)) begin
        cur_score = acc_q[i];
      end
    end

    case (state_q)
      ST_ACCUM: begin
        if (v2_q && (cnt2_q == LAST_CLS)) begin
          if (sweep_q == LAST_SWEEP) begin
            sweep_d    = '0;
            scan_idx_d = '0;
            state_d    = ST_SCAN;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        // strict compare keeps the lowest index on ties
        if ((scan_idx_q == '0) || (cur_score > best_score_q)) begin
          cand_idx   = scan_idx_q;
          cand_score = cur_score;
        end
        best_idx_d   = cand_idx;
        best_score_d = cand_score;
        if (scan_idx_q == LAST_CLS) begin
          state_d       = ST_DONE;
          class_idx_d   = cand_idx;
          class_score_d = cand_score;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        acc_d      = '{default: '0};
`ifdef CHOOSE2_ACC_SATURATE_EN
        sat_d      = '0;
`endif
        scan_idx_d = '0;
        state_d    = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase

    // clear overrides everything, including a final sweep ending this cycle
    if (clear) begin
      state_d       = ST_ACCUM;
      v1_d          = 1'b0;
      v2_d          = 1'b0;
      acc_d         = '{default: '0};
      sweep_d       = '0;
      scan_idx_d    = '0;
      class_idx_d   = class_idx_q;
      class_score_d = class_score_q;
`ifdef CHOOSE2_ACC_SATURATE_EN
      sat_d         = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ACCUM;
      v1_q          <= 1'b0;
      cnt1_q        <= '0;
      f1_q          <= '0;
      v2_q          <= 1'b0;
      cnt2_q        <= '0;
      prod_q        <= '0;
      acc_q         <= '{default: '0};
      sweep_q       <= '0;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
`ifdef CHOOSE2_ACC_SATURATE_EN
      sat_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      v1_q          <= v1_d;
      cnt1_q        <= cnt1_d;
      f1_q          <= f1_d;
      v2_q          <= v2_d;
      cnt2_q        <= cnt2_d;
      prod_q        <= prod_d;
      acc_q         <= acc_d;
      sweep_q       <= sweep_d;
      scan_idx_q    <= scan_idx_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
`ifdef CHOOSE2_ACC_SATURATE_EN
      sat_q         <= sat_d;
`endif
    end
  end

  assign busy         = (state_q != ST_ACCUM);
  assign result_valid = (state_q == ST_DONE);
  assign class_idx    = class_idx_q;
  assign class_score  = class_score_q;

endmodule

// File: tb/tb_choose2_accum.sv
module tb_choose2_accum;

  localparam int MA = 4;
  localparam int ON = 4;
  localparam int IN = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clear = 1'b0;
  logic                 rd_en = 1'b0;
  logic [MA-1:0]        weight_cnt = '0;
  logic [DW-1:0]        feature_in = '0;
  logic [DW-1:0]        weight_in = '0;
  logic                 busy;
  logic                 result_valid;
  logic [MA-1:0]        class_idx;
  logic signed [AW-1:0] class_score;

  int checks = 0;
  int passed = 0;

  int feat_a [IN];
  int wt_a [IN][ON];
  int last_ei = 0;
  logic signed [AW-1:0] last_es = '0;

  choose2_accum #(
    .MEM_ADDR  (MA),
    .OUTPUT_NUM(ON),
    .INPUT_NUM (IN),
    .DATA_W    (DW),
    .ACC_W     (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .rd_en       (rd_en),
    .weight_cnt  (weight_cnt),
    .feature_in  (feature_in),
    .weight_in   (weight_in),
    .busy        (busy),
    .result_valid(result_valid),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  always #5 clk = ~clk;

  function automatic longint wrapa(input longint v);
    longint m;
    m = v & ((64'sd1 <<< AW) - 1);
    if (m >= (64'sd1 <<< (AW - 1))) m = m - (64'sd1 <<< AW);
    return m;
  endfunction

  // Reference: per-class sum of feature*weight over all sweeps, then argmax
  task automatic model(output int eidx, output logic signed [AW-1:0] escore);
    longint a [ON];
    bit     sat [ON];
    longint best;
    for (int c = 0; c < ON; c++) begin
      a[c] = 0;
      sat[c] = 0;
      for (int s = 0; s < IN; s++) begin
        if (!sat[c]) begin
          a[c] = a[c] + longint'(feat_a[s]) * longint'(wt_a[s][c]);
`ifdef CHOOSE2_ACC_SATURATE_EN
          if (a[c] > AMAX) begin a[c] = AMAX; sat[c] = 1; end
          else if (a[c] < AMIN) begin a[c] = AMIN; sat[c] = 1; end
`else
          a[c] = wrapa(a[c]);
`endif
        end
      end
    end
    best = a[0];
    eidx = 0;
    for (int c = 1; c < ON; c++) begin
      if (a[c] > best) begin best = a[c]; eidx = c; end
    end
    escore = AW'(best);
    last_ei = eidx;
    last_es = escore;
  endtask

  task automatic rand_vectors();
    for (int s = 0; s < IN; s++) begin
      feat_a[s] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < ON; c++) wt_a[s][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Drives the first n sweep entries; gaps inserts idle cycles and
  // out-of-range class indices. Returns after the edge sampling the last entry.
  task automatic feed(input bit gaps, input int n);
    logic [DW-1:0] pw;
    bit pv;
    pv = 0;
    pw = '0;
    for (int k = 0; k < n; k++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        weight_in = pv ? pw : DW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          rd_en = 1'b1;
          weight_cnt = MA'($urandom_range(ON, 15));
          feature_in = DW'($urandom);
          pv = 1;
          pw = DW'($urandom);
        end else begin
          rd_en = 1'b0;
          pv = 0;
        end
      end
      @(negedge clk);
      weight_in = pv ? pw : DW'($urandom);
      rd_en = 1'b1;
      weight_cnt = MA'(k % ON);
      feature_in = DW'(feat_a[k / ON]);
      pv = 1;
      pw = DW'(wt_a[k / ON][k % ON]);
    end
    @(negedge clk);
    rd_en = 1'b0;
    weight_in = pw;
    feature_in = DW'($urandom);
    weight_cnt = MA'($urandom);
  endtask

  task automatic wait_result(input bit hold, output int lat, output int busy_n, output int rv_n,
                             output logic [MA-1:0] idx, output logic signed [AW-1:0] score,
                             output bit tout);
    int edges;
    bit got;
    edges = 1; got = 0; lat = 0; busy_n = 0; rv_n = 0; idx = '0; score = '0; tout = 1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_n++;
      if (result_valid) begin
        rv_n++;
        if (!got) begin got = 1; lat = edges; idx = class_idx; score = class_score; end
      end
      if (hold) begin
        rd_en = busy;
        weight_cnt = MA'($urandom_range(0, ON - 1));
        feature_in = DW'($urandom);
      end
      weight_in = DW'($urandom);
      if (got && !busy) begin tout = 0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (result_valid !== 1'b0) $display("FAIL reset_rv got %b exp 0", result_valid); else passed++;
    checks++; if (class_idx !== '0) $display("FAIL reset_idx got %0d exp 0", class_idx); else passed++;
    checks++; if (class_score !== '0) $display("FAIL reset_score got %0d exp 0", class_score); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_case1();
    rand_vectors();
    feat_a[0] = 1; feat_a[1] = 2; feat_a[2] = 0; feat_a[3] = 0;
    wt_a[0][0] = 3; wt_a[0][1] = -1; wt_a[0][2] = 5; wt_a[0][3] = 0;
    wt_a[1][0] = 1; wt_a[1][1] = 1;  wt_a[1][2] = 1; wt_a[1][3] = 7;
  endtask

  task automatic test_case1();
    int lat, bn, rn, ei; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es; bit to;
    load_case1();
    model(ei, es);
    feed(0, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    checks++; if (to) $display("FAIL case1_timeout got none exp result"); else passed++;
    checks++; if (lat != ON + 3) $display("FAIL case1_latency got %0d exp %0d", lat, ON + 3); else passed++;
    checks++; if (bn != ON + 1) $display("FAIL case1_busy_cycles got %0d exp %0d", bn, ON + 1); else passed++;
    checks++; if (rn != 1) $display("FAIL case1_rv_cycles got %0d exp 1", rn); else passed++;
    checks++; if (gi !== 4'd3) $display("FAIL case1_idx got %0d exp 3", gi); else passed++;
    checks++; if (gs !== 16'sd14) $display("FAIL case1_score got %0d exp 14", gs); else passed++;
    checks++; if (gs !== es) $display("FAIL case1_model got %0d exp %0d", gs, es); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (class_idx !== 4'd3) $display("FAIL case1_hold got %0d exp 3", class_idx); else passed++;
  endtask

  task automatic test_ties();
    int lat, bn, rn; logic [MA-1:0] gi; logic signed [AW-1:0] gs; bit to;
    rand_vectors();
    feat_a[0] = 1; feat_a[1] = 0; feat_a[2] = 0; feat_a[3] = 0;
    for (int c = 0; c < ON; c++) wt_a[0][c] = 2;
    feed(1, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    last_ei = 0; last_es = 16'sd2;
    checks++; if (to || gi !== 4'd0) $display("FAIL ties_idx got %0d exp 0", gi); else passed++;
    checks++; if (gs !== 16'sd2) $display("FAIL ties_score got %0d exp 2", gs); else passed++;
  endtask

  task automatic test_negative();
    int lat, bn, rn; logic [MA-1:0] gi; logic signed [AW-1:0] gs; bit to;
    rand_vectors();
    feat_a[0] = 1; feat_a[1] = 0; feat_a[2] = 0; feat_a[3] = 0;
    wt_a[0][0] = -4; wt_a[0][1] = -2; wt_a[0][2] = -9; wt_a[0][3] = -3;
    feed(1, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    last_ei = 1; last_es = -16'sd2;
    checks++; if (to || gi !== 4'd1) $display("FAIL neg_idx got %0d exp 1", gi); else passed++;
    checks++; if (gs !== -16'sd2) $display("FAIL neg_score got %0d exp -2", gs); else passed++;
  endtask

  task automatic test_scan_hold();
    int lat, bn, rn, ei; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es; bit to;
    for (int r = 0; r < 2; r++) begin
      rand_vectors();
      model(ei, es);
      feed(1, IN * ON);
      wait_result(r == 0, lat, bn, rn, gi, gs, to);
      checks++; if (to || gi !== MA'(ei)) $display("FAIL hold%0d_idx got %0d exp %0d", r, gi, ei); else passed++;
      checks++; if (gs !== es) $display("FAIL hold%0d_score got %0d exp %0d", r, gs, es); else passed++;
      checks++; if (lat != ON + 3) $display("FAIL hold%0d_latency got %0d exp %0d", r, lat, ON + 3); else passed++;
    end
  endtask

  task automatic test_clear();
    int lat, bn, rn, ei, pi; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es, ps; bit to;
    pi = last_ei; ps = last_es;
    load_case1();
    feed(0, ON + 2);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    bn = 0; rn = 0;
    repeat (20) begin @(negedge clk); if (busy) bn++; if (result_valid) rn++; end
    checks++; if (bn != 0) $display("FAIL clear_busy got %0d exp 0", bn); else passed++;
    checks++; if (rn != 0) $display("FAIL clear_rv got %0d exp 0", rn); else passed++;
    checks++; if (class_idx !== MA'(pi)) $display("FAIL clear_held_idx got %0d exp %0d", class_idx, pi); else passed++;
    checks++; if (class_score !== ps) $display("FAIL clear_held_score got %0d exp %0d", class_score, ps); else passed++;
    model(ei, es);
    feed(0, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    checks++; if (to || gi !== 4'd3) $display("FAIL clear_rerun_idx got %0d exp 3", gi); else passed++;
    checks++; if (gs !== 16'sd14) $display("FAIL clear_rerun_score got %0d exp 14", gs); else passed++;
    checks++; if (lat != ON + 3) $display("FAIL clear_rerun_latency got %0d exp %0d", lat, ON + 3); else passed++;
  endtask

  task automatic test_clear_final();
    int lat, bn, rn, ei, pi; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es, ps; bit to;
    pi = last_ei; ps = last_es;
    rand_vectors();
    feed(1, IN * ON);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    bn = 0; rn = 0;
    repeat (20) begin @(negedge clk); if (busy) bn++; if (result_valid) rn++; end
    checks++; if (bn != 0 || rn != 0) $display("FAIL clrfinal_quiet got busy %0d rv %0d exp 0 0", bn, rn); else passed++;
    checks++; if (class_idx !== MA'(pi)) $display("FAIL clrfinal_held_idx got %0d exp %0d", class_idx, pi); else passed++;
    checks++; if (class_score !== ps) $display("FAIL clrfinal_held_score got %0d exp %0d", class_score, ps); else passed++;
    rand_vectors();
    model(ei, es);
    feed(1, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    checks++; if (to || gi !== MA'(ei)) $display("FAIL clrfinal_idx got %0d exp %0d", gi, ei); else passed++;
    checks++; if (gs !== es) $display("FAIL clrfinal_score got %0d exp %0d", gs, es); else passed++;
    checks++; if (lat != ON + 3) $display("FAIL clrfinal_latency got %0d exp %0d", lat, ON + 3); else passed++;
  endtask

  task automatic test_wrap();
    int lat, bn, rn, ei; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es, cs; bit to;
    for (int s = 0; s < IN; s++) begin
      feat_a[s] = 127;
      for (int c = 0; c < ON; c++) wt_a[s][c] = 127;
    end
`ifdef CHOOSE2_ACC_SATURATE_EN
    cs = 16'sd32767;
`else
    cs = AW'(IN * 127 * 127 - 65536);
`endif
    model(ei, es);
    feed(0, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    checks++; if (to || gi !== 4'd0) $display("FAIL wrap_idx got %0d exp 0", gi); else passed++;
    checks++; if (gs !== cs) $display("FAIL wrap_score got %0d exp %0d", gs, cs); else passed++;
    checks++; if (gs !== es) $display("FAIL wrap_model got %0d exp %0d", gs, es); else passed++;
  endtask

  task automatic test_random();
    int lat, bn, rn, ei; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es; bit to;
    for (int r = 0; r < 6; r++) begin
      rand_vectors();
      model(ei, es);
      feed(1, IN * ON);
      wait_result(0, lat, bn, rn, gi, gs, to);
      checks++; if (to || gi !== MA'(ei)) $display("FAIL rand%0d_idx got %0d exp %0d", r, gi, ei); else passed++;
      checks++; if (gs !== es) $display("FAIL rand%0d_score got %0d exp %0d", r, gs, es); else passed++;
      checks++; if (bn != ON + 1 || rn != 1) $display("FAIL rand%0d_timing got busy %0d rv %0d exp %0d 1", r, bn, rn, ON + 1); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, rn, ei; logic [MA-1:0] gi; logic signed [AW-1:0] gs, es; bit to, seen;
    rand_vectors();
    feed(1, IN * ON);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin seen = 1; break; end
    end
    checks++; if (!seen) $display("FAIL rstmid_busy got 0 exp 1"); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL rstmid_flags got %b%b exp 00", busy, result_valid); else passed++;
    checks++; if (class_idx !== '0 || class_score !== '0) $display("FAIL rstmid_out got %0d %0d exp 0 0", class_idx, class_score); else passed++;
    @(negedge clk); reset = 1'b1;
    rand_vectors();
    model(ei, es);
    feed(1, IN * ON);
    wait_result(0, lat, bn, rn, gi, gs, to);
    checks++; if (to || gi !== MA'(ei)) $display("FAIL rstmid_idx got %0d exp %0d", gi, ei); else passed++;
    checks++; if (gs !== es) $display("FAIL rstmid_score got %0d exp %0d", gs, es); else passed++;
  endtask

  initial begin
    test_reset();
    test_case1();
    test_ties();
    test_negative();
    test_scan_hold();
    test_clear();
    test_clear_final();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
